gray_stream_convert: RTL and testbench
======================================

Name: gray_stream_convert

Overview:
- Parametrised pixel-stream converter between the input FIFO (first-word-fall-through read side) and the output FIFO (write side) inside dut_system.
- Successor to the fixed 24->24 / 24->8 path: multiple pixels per word, three output modes, programmable luma coefficients with saturation, full backpressure handling, and frame/line accounting with a frame_done pulse.

Parameters:
- MODE, 1: output format. 0 = RGB passthrough (24b/pixel); 1 = grayscale (8b/pixel); 2 = grayscale replicated to 24b/pixel.
- PIXELS_PER_WORD, 1: pixels per FIFO word. Legal values are 1, 2 and 4.
- IMG_WIDTH, 720: pixels per line. Must be a multiple of PIXELS_PER_WORD.
- IMG_HEIGHT, 540: lines per frame.
- COEF_R, 77: red weight, 8-bit unsigned.
- COEF_G, 150: green weight, 8-bit unsigned.
- COEF_B, 29: blue weight, 8-bit unsigned.
- DWIDTH_IN, 24*PIXELS_PER_WORD: input word width (derived).
- DWIDTH_OUT, (MODE==1 ? 8 : 24)*PIXELS_PER_WORD: output word width (derived).

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  when low, no new input reads; in-flight words drain.
- in_dout  in  DWIDTH_IN  input FIFO data, FWFT (valid while in_empty=0).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  input FIFO pop.
- out_din  out  DWIDTH_OUT  output FIFO data.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  output FIFO push.
- frame_done  out  1  one-cycle pulse on the last word of a frame.
- frame_count  out  16  completed frames, wraps at 65535 -> 0.
- busy  out  1  any pipeline stage valid, or mid-frame.

Behaviour:
- Reset: when reset=0 at a rising edge, every valid bit, counter, out_din, out_wr_en, in_rd_en, frame_done, frame_count and busy goes to 0.
  - Applies mid-frame too: in-flight words are discarded and counting restarts at pixel 0, line 0.
- Word layout: pixel 0 occupies the most significant bits. Each 24-bit pixel is [23:16]=B, [15:8]=G, [7:0]=R (BMP byte order).
  - MODE 2 places the gray value in all three bytes of each pixel.
  - MODE 0 copies each pixel unchanged.
- Pipeline, 3 registered stages:
  - S0: capture in_dout.
  - S1: per-pixel products R*COEF_R, G*COEF_G, B*COEF_B (16b each).
  - S2: 18b sum, >>8, saturate to 255, format per MODE.
  - MODE 0 carries the data through all stages unchanged, so latency is identical in every mode.
- Stall: advance = !out_full.
  - When out_full=1, all stages hold and in_rd_en=0.
- Read: in_rd_en = enable & !in_empty & advance (combinational). S0 loads in_dout in the same cycle.
- Write: out_wr_en = s2_valid & !out_full (combinational from registered valid). out_din is the registered S2 data and holds while stalled.
- Latency: a word popped at edge N is pushed at edge N+3 when no stall occurs. Throughput is 1 word/clock.
- No word is dropped or duplicated across any full/empty/enable pattern, including simultaneous out_full rise and in_empty fall.
- Counters: word column counter 0..IMG_WIDTH/PIXELS_PER_WORD-1 and line counter 0..IMG_HEIGHT-1. Both advance on each accepted output write.
  - On the write of the last column of the last line: frame_done=1 for that cycle, both counters return to 0, frame_count increments.
- busy = any of s0/s1/s2 valid, or column/line counter nonzero.
- enable low mid-frame: reading pauses and counters hold their position. Reading resumes at the same position when enable returns high.

Test Plan:
- MODE=1, PPW=1, in_dout 0xFFFFFF then 0x0000FF, 0x00FF00, 0xFF0000 -> out_din 0xFF, 0x4C, 0x95, 0x1C, first out_wr_en exactly 3 cycles after first in_rd_en.
- COEF_R=100, COEF_G=150, COEF_B=50, input 0xFFFFFF -> saturates to 0xFF (raw 298); input 0x101010 -> 0x12.
- MODE=2, PPW=2, in_dout 0x0000FF_FFFFFF -> out_din 0x4C4C4C_FFFFFF; MODE=0 same input -> unchanged.
- IMG_WIDTH=4, IMG_HEIGHT=2, PPW=1, 8 words streamed -> frame_done high only on 8th out_wr_en, frame_count=1; 16 words -> frame_count=2.
- out_full asserted for 5 cycles mid-stream with random in_empty gaps and enable toggles -> output sequence equals the reference model with no loss or duplication, and out_din is stable during the stall.
- reset=0 for one cycle after 3 words of an 8-word frame -> all outputs 0 next cycle; the following 8 words produce exactly one frame_done, frame_count=1.

Source files
------------

// File: rtl/gray_stream_convert.sv
// Pixel-stream converter between an FWFT input FIFO and an output FIFO:
// RGB passthrough, 8-bit luma or replicated luma, with frame/line accounting.
module gray_stream_convert #(
  parameter int MODE            = 1,
  parameter int PIXELS_PER_WORD = 1,
  parameter int IMG_WIDTH       = 720,
  parameter int IMG_HEIGHT      = 540,
  parameter int COEF_R          = 77,
  parameter int COEF_G          = 150,
  parameter int COEF_B          = 29,
  parameter int DWIDTH_IN       = 24 * PIXELS_PER_WORD,
  parameter int DWIDTH_OUT      = (MODE == 1 ? 8 : 24) * PIXELS_PER_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DWIDTH_IN-1:0]  in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DWIDTH_OUT-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  busy
);
  localparam int PPW    = PIXELS_PER_WORD;
  localparam int COLS   = IMG_WIDTH / PPW;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);

  logic                  advance, last_col, last_line;
  logic                  run_q, run_d;
  logic                  s0_valid_q, s0_valid_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DWIDTH_IN-1:0]  s0_data_q, s0_data_d;
  logic [DWIDTH_OUT-1:0] s2_data_q, s2_data_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [15:0]           frame_count_q, frame_count_d;
  wire  [DWIDTH_OUT-1:0] s2_fmt;

  // run_q keeps the first cycle after reset free of pops so every output reads zero there.
  always_comb begin
    advance     = !out_full;
    in_rd_en    = reset & run_q & enable & !in_empty & advance;
    out_wr_en   = s2_valid_q & !out_full;
    last_col    = (col_q == LAST_COL);
    last_line   = (line_q == LAST_LINE);
    frame_done  = out_wr_en & last_col & last_line;
    busy        = s0_valid_q | s1_valid_q | s2_valid_q | (col_q != '0) | (line_q != '0);
    out_din     = s2_data_q;
    frame_count = frame_count_q;
  end

  always_comb begin
    run_d      = 1'b1;
    s0_valid_d = s0_valid_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s0_data_d  = s0_data_q;
    s2_data_d  = s2_data_q;
    if (advance) begin
      s0_valid_d = in_rd_en;
      s1_valid_d = s0_valid_q;
      s2_valid_d = s1_valid_q;
      if (in_rd_en)   s0_data_d = in_dout;
      if (s1_valid_q) s2_data_d = s2_fmt;
    end
  end

  always_comb begin
    col_d         = col_q;
    line_d        = line_q;
    frame_count_d = frame_count_q;
    if (out_wr_en) begin
      if (last_col) begin
        col_d = '0;
        if (last_line) begin
          line_d        = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          line_d = line_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q         <= 1'b0;
      s0_valid_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s0_data_q     <= '0;
      s2_data_q     <= '0;
      col_q         <= '0;
      line_q        <= '0;
      frame_count_q <= '0;
    end else begin
      run_q         <= run_d;
      s0_valid_q    <= s0_valid_d;
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      s0_data_q     <= s0_data_d;
      s2_data_q     <= s2_data_d;
      col_q         <= col_d;
      line_q        <= line_d;
      frame_count_q <= frame_count_d;
    end
  end

  if (MODE == 0) begin : g_pass
    logic [DWIDTH_IN-1:0] s1_data_q, s1_data_d;

    always_comb begin
      s1_data_d = s1_data_q;
      if (advance && s0_valid_q) s1_data_d = s0_data_q;
    end

    always_ff @(posedge clock) begin
      if (!reset) s1_data_q <= '0;
      else        s1_data_q <= s1_data_d;
    end

    assign s2_fmt = s1_data_q;
  end else begin : g_luma
    localparam logic [15:0] CR = {8'd0, 8'(COEF_R)};
    localparam logic [15:0] CG = {8'd0, 8'(COEF_G)};
    localparam logic [15:0] CB = {8'd0, 8'(COEF_B)};
    logic [PPW-1:0][15:0] prod_r_q, prod_r_d;
    logic [PPW-1:0][15:0] prod_g_q, prod_g_d;
    logic [PPW-1:0][15:0] prod_b_q, prod_b_d;

    // Pixel i sits MSB-first; within a pixel the byte order is B, G, R from the top.
    always_comb begin
      prod_r_d = prod_r_q;
      prod_g_d = prod_g_q;
      prod_b_d = prod_b_q;
      if (advance && s0_valid_q) begin
        for (int i = 0; i < PPW; i++) begin
          prod_b_d[i] = 16'(s0_data_q[DWIDTH_IN-1-24*i -: 8]) * CB;
          prod_g_d[i] = 16'(s0_data_q[DWIDTH_IN-9-24*i -: 8]) * CG;
          prod_r_d[i] = 16'(s0_data_q[DWIDTH_IN-17-24*i -: 8]) * CR;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        prod_r_q <= '0;
        prod_g_q <= '0;
        prod_b_q <= '0;
      end else begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
    end

    for (genvar g = 0; g < PPW; g++) begin : g_pix
      logic [9:0] scaled;
      logic [7:0] gray;
      assign scaled = 10'((18'(prod_r_q[g]) + 18'(prod_g_q[g]) + 18'(prod_b_q[g])) >> 8);
      assign gray   = (scaled > 10'd255) ? 8'hFF : scaled[7:0];
      if (MODE == 1) begin : g_y
        assign s2_fmt[DWIDTH_OUT-1-8*g -: 8] = gray;
      end else begin : g_rgb
        assign s2_fmt[DWIDTH_OUT-1-24*g -: 24] = {3{gray}};
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_convert.sv
// Scoreboard bench: a 4x2-frame luma instance for streaming/stall/frame tests,
// plus three small instances covering replicated, passthrough and saturating formats.
module tb_gray_stream_convert;
  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [23:0] a_in_dout  = '0;
  logic        a_in_empty = 1'b1;
  logic        a_out_full = 1'b0;
  logic        a_in_rd_en, a_out_wr_en, a_frame_done, a_busy;
  logic [7:0]  a_out_din;
  logic [15:0] a_frame_count;

  logic [47:0] s_in48    = '0;
  logic [23:0] s_in24    = '0;
  logic        s_empty48 = 1'b1;
  logic        s_empty24 = 1'b1;
  logic        s_full    = 1'b0;
  logic        b_rd, b_wr, b_fd, b_busy, c_rd, c_wr, c_fd, c_busy, d_rd, d_wr, d_fd, d_busy;
  logic [47:0] b_dout, c_dout;
  logic [7:0]  d_dout;
  logic [15:0] b_fc, c_fc, d_fc;

  gray_stream_convert #(.MODE(1), .PIXELS_PER_WORD(1), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .in_dout(a_in_dout), .in_empty(a_in_empty),
    .in_rd_en(a_in_rd_en), .out_din(a_out_din), .out_full(a_out_full), .out_wr_en(a_out_wr_en),
    .frame_done(a_frame_done), .frame_count(a_frame_count), .busy(a_busy));

  gray_stream_convert #(.MODE(2), .PIXELS_PER_WORD(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .in_dout(s_in48), .in_empty(s_empty48),
    .in_rd_en(b_rd), .out_din(b_dout), .out_full(s_full), .out_wr_en(b_wr),
    .frame_done(b_fd), .frame_count(b_fc), .busy(b_busy));

  gray_stream_convert #(.MODE(0), .PIXELS_PER_WORD(2)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .in_dout(s_in48), .in_empty(s_empty48),
    .in_rd_en(c_rd), .out_din(c_dout), .out_full(s_full), .out_wr_en(c_wr),
    .frame_done(c_fd), .frame_count(c_fc), .busy(c_busy));

  gray_stream_convert #(.MODE(1), .PIXELS_PER_WORD(1), .COEF_R(100), .COEF_G(150), .COEF_B(50)) dut_d (
    .clock(clock), .reset(reset), .enable(enable), .in_dout(s_in24), .in_empty(s_empty24),
    .in_rd_en(d_rd), .out_din(d_dout), .out_full(s_full), .out_wr_en(d_wr),
    .frame_done(d_fd), .frame_count(d_fc), .busy(d_busy));

  logic [23:0] src_q[$];
  logic [7:0]  exp_q[$];
  int          wr_total = 0;
  logic [15:0] fc_model = '0;

  function automatic logic [7:0] luma(input logic [23:0] p, input int cr, input int cg, input int cb);
    int s;
    s = (int'(p[7:0]) * cr + int'(p[15:8]) * cg + int'(p[23:16]) * cb) / 256;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  // Drives one cycle into dut_a from the modelled FIFO and samples what the coming edge will do.
  task automatic drive_cycle(input logic full, input logic gap, input logic en,
                             output logic rd, output logic wr, output logic fd,
                             output logic [7:0] dout, output logic [15:0] fc);
    @(negedge clock);
    enable     = en;
    a_out_full = full;
    a_in_empty = gap || (src_q.size() == 0);
    a_in_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
    #1;
    rd   = a_in_rd_en;
    wr   = a_out_wr_en;
    fd   = a_frame_done;
    dout = a_out_din;
    fc   = a_frame_count;
    if (rd === 1'b1 && src_q.size() != 0) begin
      exp_q.push_back(luma(src_q[0], 77, 150, 29));
      void'(src_q.pop_front());
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    wr_total = 0;
    fc_model = '0;
    #1;
  endtask

  task automatic test_reset();
    enable     = 1'b1;
    a_in_empty = 1'b0;
    a_in_dout  = 24'hABCDEF;
    a_out_full = 1'b0;
    apply_reset();
    checks += 6;
    if (a_out_din !== 8'h00)      begin errors++; $display("[TB] FAIL reset_out_din: got %h, required 00", a_out_din); end
    if (a_out_wr_en !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wr_en: got %b, required 0", a_out_wr_en); end
    if (a_in_rd_en !== 1'b0)      begin errors++; $display("[TB] FAIL reset_rd_en: got %b, required 0", a_in_rd_en); end
    if (a_frame_done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_frame_done: got %b, required 0", a_frame_done); end
    if (a_frame_count !== 16'd0)  begin errors++; $display("[TB] FAIL reset_frame_count: got %0d, required 0", a_frame_count); end
    if (a_busy !== 1'b0)          begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", a_busy); end
  endtask

  task automatic test_gray_basic();
    logic rd, wr, fd;
    logic [7:0] dout, e;
    logic [15:0] fc;
    logic [7:0] want [4] = '{8'hFF, 8'h4C, 8'h95, 8'h1C};
    int first_rd = -1;
    int first_wr = -1;
    int n = 0;
    src_q = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, rd, wr, fd, dout, fc);
      if (rd === 1'b1 && first_rd < 0) first_rd = cyc;
      if (wr === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks += 2;
        if (dout !== e)       begin errors++; $display("[TB] FAIL gray_basic_sb word %0d: got %h, required %h", n, dout, e); end
        if (dout !== want[n]) begin errors++; $display("[TB] FAIL gray_basic_const word %0d: got %h, required %h", n, dout, want[n]); end
        n++;
      end
    end
    checks += 2;
    if (n != 4) begin errors++; $display("[TB] FAIL gray_basic_count: got %0d writes, required 4", n); end
    if (first_wr - first_rd != 3) begin
      errors++; $display("[TB] FAIL gray_latency: got %0d cycles, required 3", first_wr - first_rd);
    end
  endtask

  task automatic test_frames();
    logic rd, wr, fd, exp_fd;
    logic [7:0] dout, e;
    logic [15:0] fc;
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) src_q.push_back(24'($urandom()));
    for (int cyc = 0; cyc < 80 && wr_total < 16; cyc++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, rd, wr, fd, dout, fc);
      checks++;
      if (fc !== fc_model) begin errors++; $display("[TB] FAIL frames_count cyc %0d: got %0d, required %0d", cyc, fc, fc_model); end
      exp_fd = 1'b0;
      if (wr === 1'b1) begin
        exp_fd = (wr_total % 8 == 7);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== e) begin errors++; $display("[TB] FAIL frames_data write %0d: got %h, required %h", wr_total, dout, e); end
        wr_total++;
      end
      checks++;
      if (fd !== exp_fd) begin errors++; $display("[TB] FAIL frames_done write %0d: got %b, required %b", wr_total, fd, exp_fd); end
      if (fd === 1'b1) pulses++;
      if (exp_fd) fc_model++;
    end
    @(negedge clock);
    #1;
    checks += 4;
    if (wr_total != 16)          begin errors++; $display("[TB] FAIL frames_timeout: got %0d writes, required 16", wr_total); end
    if (pulses != 2)             begin errors++; $display("[TB] FAIL frames_pulses: got %0d, required 2", pulses); end
    if (a_frame_count !== 16'd2) begin errors++; $display("[TB] FAIL frames_final_count: got %0d, required 2", a_frame_count); end
    if (a_busy !== 1'b0)         begin errors++; $display("[TB] FAIL frames_idle_busy: got %b, required 0", a_busy); end
  endtask

  task automatic test_stall();
    logic rd, wr, fd, exp_fd, full, gap, en;
    logic prev_full = 1'b0;
    logic [7:0] dout, e;
    logic [7:0] prev_dout = '0;
    logic [15:0] fc;
    apply_reset();
    for (int i = 0; i < 12; i++) src_q.push_back(24'($urandom()));
    for (int cyc = 0; cyc < 300 && wr_total < 12; cyc++) begin
      full = (cyc >= 6 && cyc < 11);
      gap  = (cyc == 5) ? 1'b1 : (cyc == 6) ? 1'b0 : ($urandom_range(0, 3) == 0);
      en   = (cyc == 6) ? 1'b1 : ($urandom_range(0, 4) != 0);
      drive_cycle(full, gap, en, rd, wr, fd, dout, fc);
      if (full) begin
        checks += 2;
        if (wr !== 1'b0) begin errors++; $display("[TB] FAIL stall_wr cyc %0d: got %b, required 0", cyc, wr); end
        if (rd !== 1'b0) begin errors++; $display("[TB] FAIL stall_rd cyc %0d: got %b, required 0", cyc, rd); end
        if (prev_full) begin
          checks++;
          if (dout !== prev_dout) begin errors++; $display("[TB] FAIL stall_hold cyc %0d: got %h, required %h", cyc, dout, prev_dout); end
        end
      end
      exp_fd = 1'b0;
      if (wr === 1'b1) begin
        exp_fd = (wr_total % 8 == 7);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== e) begin errors++; $display("[TB] FAIL stall_data write %0d: got %h, required %h", wr_total, dout, e); end
        wr_total++;
      end
      checks++;
      if (fd !== exp_fd) begin errors++; $display("[TB] FAIL stall_done write %0d: got %b, required %b", wr_total, fd, exp_fd); end
      prev_full = full;
      prev_dout = dout;
    end
    checks += 2;
    if (wr_total != 12)     begin errors++; $display("[TB] FAIL stall_timeout: got %0d writes, required 12", wr_total); end
    if (exp_q.size() != 0)  begin errors++; $display("[TB] FAIL stall_leftover: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic rd, wr, fd, exp_fd;
    logic [7:0] dout, e;
    logic [15:0] fc;
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom()));
    for (int cyc = 0; cyc < 30 && wr_total < 3; cyc++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, rd, wr, fd, dout, fc);
      if (wr === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== e) begin errors++; $display("[TB] FAIL midreset_pre_data write %0d: got %h, required %h", wr_total, dout, e); end
        wr_total++;
      end
    end
    apply_reset();
    checks += 5;
    if (a_out_din !== 8'h00)     begin errors++; $display("[TB] FAIL midreset_out_din: got %h, required 00", a_out_din); end
    if (a_out_wr_en !== 1'b0)    begin errors++; $display("[TB] FAIL midreset_wr_en: got %b, required 0", a_out_wr_en); end
    if (a_in_rd_en !== 1'b0)     begin errors++; $display("[TB] FAIL midreset_rd_en: got %b, required 0", a_in_rd_en); end
    if (a_frame_count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d, required 0", a_frame_count); end
    if (a_busy !== 1'b0)         begin errors++; $display("[TB] FAIL midreset_busy: got %b, required 0", a_busy); end
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom()));
    for (int cyc = 0; cyc < 40 && wr_total < 8; cyc++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, rd, wr, fd, dout, fc);
      exp_fd = 1'b0;
      if (wr === 1'b1) begin
        exp_fd = (wr_total == 7);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (dout !== e) begin errors++; $display("[TB] FAIL midreset_data write %0d: got %h, required %h", wr_total, dout, e); end
        wr_total++;
      end
      checks++;
      if (fd !== exp_fd) begin errors++; $display("[TB] FAIL midreset_done write %0d: got %b, required %b", wr_total, fd, exp_fd); end
      if (fd === 1'b1) pulses++;
    end
    @(negedge clock);
    #1;
    checks += 2;
    if (pulses != 1)             begin errors++; $display("[TB] FAIL midreset_pulses: got %0d, required 1", pulses); end
    if (a_frame_count !== 16'd1) begin errors++; $display("[TB] FAIL midreset_final_count: got %0d, required 1", a_frame_count); end
  endtask

  task automatic test_formats();
    logic [47:0] q48[$];
    logic [23:0] q24[$];
    logic [47:0] eb[$];
    logic [47:0] ec[$];
    logic [7:0]  ed[$];
    logic [47:0] w, e48;
    logic [7:0]  g0, g1, e8;
    int nb = 0;
    int nc = 0;
    int nd = 0;
    q48 = {48'h0000FF_FFFFFF, 48'h00FF00_101010};
    q24 = {24'hFFFFFF, 24'h101010};
    for (int cyc = 0; cyc < 40 && !(nb == 2 && nc == 2 && nd == 2); cyc++) begin
      @(negedge clock);
      enable    = 1'b1;
      s_full    = 1'b0;
      s_empty48 = (q48.size() == 0);
      s_in48    = s_empty48 ? 48'h0 : q48[0];
      s_empty24 = (q24.size() == 0);
      s_in24    = s_empty24 ? 24'h0 : q24[0];
      #1;
      if (b_rd === 1'b1 && q48.size() != 0) begin
        w  = q48.pop_front();
        g0 = luma(w[47:24], 77, 150, 29);
        g1 = luma(w[23:0], 77, 150, 29);
        eb.push_back({{3{g0}}, {3{g1}}});
        ec.push_back(w);
      end
      if (d_rd === 1'b1 && q24.size() != 0) ed.push_back(luma(q24.pop_front(), 100, 150, 50));
      if (b_wr === 1'b1) begin
        e48 = (eb.size() != 0) ? eb.pop_front() : 48'hx;
        checks++;
        if (b_dout !== e48) begin errors++; $display("[TB] FAIL format_gray24 word %0d: got %h, required %h", nb, b_dout, e48); end
        nb++;
      end
      if (c_wr === 1'b1) begin
        e48 = (ec.size() != 0) ? ec.pop_front() : 48'hx;
        checks++;
        if (c_dout !== e48) begin errors++; $display("[TB] FAIL format_pass word %0d: got %h, required %h", nc, c_dout, e48); end
        nc++;
      end
      if (d_wr === 1'b1) begin
        e8 = (ed.size() != 0) ? ed.pop_front() : 8'hx;
        checks++;
        if (d_dout !== e8) begin errors++; $display("[TB] FAIL format_saturate word %0d: got %h, required %h", nd, d_dout, e8); end
        nd++;
      end
    end
    s_empty48 = 1'b1;
    s_empty24 = 1'b1;
    checks++;
    if (!(nb == 2 && nc == 2 && nd == 2)) begin
      errors++; $display("[TB] FAIL format_timeout: got %0d/%0d/%0d writes, required 2/2/2", nb, nc, nd);
    end
  endtask

  initial begin
    test_reset();
    test_gray_basic();
    test_frames();
    test_stall();
    test_reset_midframe();
    test_formats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
